// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        M1   = 3'd3,
        M2   = 3'd4
    } booth_digit_e;

    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction

    // Bit-pair recoding of {Q[1], Q[0], q_-1}.
    function automatic booth_digit_e booth_recode(input logic [2:0] triplet);
        booth_digit_e digit;
        case (triplet)
            3'b000, 3'b111: digit = ZERO;
            3'b001, 3'b010: digit = P1;
            3'b011:         digit = P2;
            3'b100:         digit = M2;
            3'b101, 3'b110: digit = M1;
            default:        digit = ZERO;
        endcase
        return digit;
    endfunction

endpackage

// File: rtl/booth_mul_seq_digit.sv
// Combinational radix-4 Booth partial-product generator: one recoded digit times M.
module booth_r4_digit
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       triplet,
    input  logic [WIDTH+1:0] m_ext,
    output logic [WIDTH+2:0] pp
);

    booth_digit_e     digit_s;
    logic [WIDTH+2:0] m1_s;
    logic [WIDTH+2:0] m2_s;

    assign digit_s = booth_recode(triplet);
    assign m1_s    = {m_ext[WIDTH+1], m_ext};
    assign m2_s    = {m_ext, 1'b0};

    // Select the signed multiple of M for this digit.
    always_comb begin
        pp = '0;
        case (digit_s)
            ZERO:    pp = '0;
            P1:      pp = m1_s;
            P2:      pp = m2_s;
            M1:      pp = -m1_s;
            M2:      pp = -m2_s;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one recoded digit per clock, signed or unsigned,
// with a start/busy/done handshake and a held 2*WIDTH-bit product.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int N     = iter_count(WIDTH);
    localparam int CNT_W = $clog2(N + 1);
    localparam int EW    = WIDTH + 2;
    localparam int AW    = WIDTH + 3;

    mul_state_e         state_r;
    mul_state_e         state_s;
    logic [EW-1:0]      m_r;
    logic [EW-1:0]      q_r;
    logic [AW-1:0]      acc_r;
    logic               qm1_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] p_r;

    logic [EW-1:0]      a_ext_s;
    logic [EW-1:0]      b_ext_s;
    logic [AW-1:0]      pp_s;
    logic [AW-1:0]      sum_s;
    logic [AW-1:0]      acc_nxt_s;
    logic [EW-1:0]      q_nxt_s;
    logic               accept_s;
    logic               last_s;

    booth_r4_digit #(.WIDTH(WIDTH)) u_digit (
        .triplet ({q_r[1], q_r[0], qm1_r}),
        .m_ext   (m_r),
        .pp      (pp_s)
    );

    // Operand extension to WIDTH+2 bits so unsigned operands stay positive.
    always_comb begin
        a_ext_s = '0;
        b_ext_s = '0;
        if (is_signed) begin
            a_ext_s = {{2{a[WIDTH-1]}}, a};
            b_ext_s = {{2{b[WIDTH-1]}}, b};
        end else begin
            a_ext_s = {2'b00, a};
            b_ext_s = {2'b00, b};
        end
    end

    // Accumulate then arithmetic-shift {A,Q,q_-1} right by two.
    assign sum_s     = acc_r + pp_s;
    assign acc_nxt_s = {{2{sum_s[AW-1]}}, sum_s[AW-1:2]};
    assign q_nxt_s   = {sum_s[1:0], q_r[EW-1:2]};

    assign accept_s  = start && (state_r != RUN);
    assign last_s    = (state_r == RUN) && (cnt_r == CNT_W'(1'b1));

    // Next-state logic; a start in DONE chains straight into RUN.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            RUN: begin
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                if (start) state_s = RUN;
                else       state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= IDLE;
            m_r     <= '0;
            q_r     <= '0;
            acc_r   <= '0;
            qm1_r   <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            p_r     <= '0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == RUN);
            done_r  <= (state_s == DONE);
            if (accept_s) begin
                m_r   <= a_ext_s;
                q_r   <= b_ext_s;
                acc_r <= '0;
                qm1_r <= 1'b0;
                cnt_r <= CNT_W'(N);
            end else if (state_r == RUN) begin
                m_r   <= m_r;
                q_r   <= q_nxt_s;
                acc_r <= acc_nxt_s;
                qm1_r <= q_r[1];
                cnt_r <= cnt_r - CNT_W'(1'b1);
            end else begin
                m_r   <= m_r;
                q_r   <= q_r;
                acc_r <= acc_r;
                qm1_r <= qm1_r;
                cnt_r <= cnt_r;
            end
            // Only the low 2*WIDTH bits carry the product; the rest is sign.
            if (last_s) p_r <= {acc_nxt_s[WIDTH-3:0], q_nxt_s};
            else        p_r <= p_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign p    = p_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and small-width sweep bench for booth_mul_seq (WIDTH 32, 4 and 8).
module tb_booth_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clr = 1'b1;
    logic        start32 = 1'b0, s32 = 1'b0, busy32, done32;
    logic [31:0] a32 = '0, b32 = '0;
    logic [63:0] p32;
    logic        start4 = 1'b0, s4 = 1'b0, busy4, done4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  p4;
    logic        start8 = 1'b0, s8 = 1'b0, busy8, done8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] p8;

    int tests = 0;
    int fails = 0;

    booth_mul_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .clr(clr), .start(start32), .is_signed(s32),
        .a(a32), .b(b32), .busy(busy32), .done(done32), .p(p32));
    booth_mul_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .clr(clr), .start(start4), .is_signed(s4),
        .a(a4), .b(b4), .busy(busy4), .done(done4), .p(p4));
    booth_mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(start8), .is_signed(s8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .p(p8));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input int w, input bit sgn,
                                            input logic [31:0] x, input logic [31:0] y);
        longint xs, ys;
        logic [63:0] pr;
        xs = longint'({32'd0, x});
        ys = longint'({32'd0, y});
        if (sgn && x[w-1]) xs = xs - (longint'(1) << w);
        if (sgn && y[w-1]) ys = ys - (longint'(1) << w);
        pr = 64'(xs * ys);
        if (w < 32) pr = pr & ((64'd1 << (2 * w)) - 64'd1);
        return pr;
    endfunction

    task automatic go32(input bit s, input logic [31:0] x, input logic [31:0] y);
        s32 = s; a32 = x; b32 = y; start32 = 1'b1;
        tick;
        start32 = 1'b0;
    endtask

    // n0 = edges already elapsed since (and including) the start edge.
    task automatic wait_done32(input string tag, input int n0, input int exp_edges);
        int n;
        bit gap;
        n = n0;
        gap = 1'b0;
        while (done32 !== 1'b1 && n < 40) begin
            if (busy32 !== 1'b1) gap = 1'b1;
            tick;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_edges));
        check({tag, "_busy_gap"}, 64'(gap), 64'd0);
        check({tag, "_busy_at_done"}, 64'(busy32), 64'd0);
    endtask

    task automatic run_small(input int w, input bit s, input logic [31:0] x, input logic [31:0] y);
        int n;
        if (w == 4) begin
            s4 = s; a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1;
        end else begin
            s8 = s; a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
        end
        tick;
        start4 = 1'b0;
        start8 = 1'b0;
        n = 1;
        while (((w == 4) ? done4 : done8) !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        check((w == 4) ? "w4_latency" : "w8_latency", 64'(n), 64'(w / 2 + 2));
        check((w == 4) ? "w4_product" : "w8_product",
              (w == 4) ? 64'(p4) : 64'(p8), ref_mul(w, s, x, y));
    endtask

    initial begin
        int seen;
        repeat (2) tick;
        check("rst_busy", 64'(busy32), 64'd0);
        check("rst_done", 64'(done32), 64'd0);
        check("rst_p", p32, 64'd0);
        check("rst_p4", 64'(p4), 64'd0);
        clr = 1'b0;
        tick;

        go32(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done32("sgn_min", 1, 18);
        check("sgn_min_p", p32, 64'h4000_0000_0000_0000);
        tick;
        check("done_one_cycle", 64'(done32), 64'd0);

        go32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done32("uns_max", 1, 18);
        check("uns_max_p", p32, 64'hFFFF_FFFE_0000_0001);
        tick;

        go32(1'b1, 32'hFFFF_FFFF, 32'd7);
        wait_done32("neg", 1, 18);
        check("neg_p", p32, 64'hFFFF_FFFF_FFFF_FFF9);
        tick;

        // back-to-back: second start issued in the DONE cycle
        go32(1'b0, 32'd3, 32'd5);
        wait_done32("b2b_1", 1, 18);
        check("b2b_1_p", p32, 64'd15);
        go32(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
        check("b2b_busy", 64'(busy32), 64'd1);
        check("b2b_p_held", p32, 64'd15);
        wait_done32("b2b_2", 1, 18);
        check("b2b_2_p", p32, 64'd6);
        tick;

        // abort with clr on edge 9
        go32(1'b1, 32'd100, 32'd200);
        repeat (8) tick;
        clr = 1'b1;
        tick;
        check("clr_busy", 64'(busy32), 64'd0);
        check("clr_done", 64'(done32), 64'd0);
        check("clr_p", p32, 64'd0);
        clr = 1'b0;
        seen = 0;
        repeat (20) begin
            tick;
            if (done32 === 1'b1) seen++;
        end
        check("clr_no_done", 64'(seen), 64'd0);
        go32(1'b0, 32'd12, 32'd12);
        wait_done32("after_clr", 1, 18);
        check("after_clr_p", p32, 64'd144);
        tick;

        // start at edge 5 with other operands is ignored
        go32(1'b0, 32'h0000_1234, 32'h0000_0010);
        repeat (4) tick;
        s32 = 1'b1; a32 = 32'hDEAD_BEEF; b32 = 32'h8765_4321; start32 = 1'b1;
        tick;
        start32 = 1'b0;
        wait_done32("ign_start", 6, 18);
        check("ign_start_p", p32, 64'h0000_0000_0001_2340);
        tick;

        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_small(4, s[0], 32'(x), 32'(y));

        run_small(8, 1'b1, 32'h80, 32'h80);
        run_small(8, 1'b0, 32'hFF, 32'hFF);
        run_small(8, 1'b1, 32'h7F, 32'h80);
        for (int i = 0; i < 400; i++)
            run_small(8, i[0], 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
